// File: rtl/amba_axi4_lite_pkg.sv
// rtl/amba_axi4_lite_pkg.sv - shared AXI4-Lite response/state types and widths
package amba_axi4_lite_pkg;

    localparam int SIZE_ADDR = 32;
    localparam int SIZE_STRB = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } master_state_e;

endpackage

// File: rtl/amba_axi4_lite_master.sv
// rtl/amba_axi4_lite_master.sv - single-outstanding AXI4-Lite initiator, optional watchdog via AXI4_LITE_MASTER_TIMEOUT_EN
module amba_axi4_lite_master
    import amba_axi4_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic                            i_cmd_write,
    input  logic [SIZE_ADDR-1:0]            i_cmd_addr,
    input  logic [31:0]                     i_cmd_wdata,
    input  logic [SIZE_STRB-1:0]            i_cmd_wstrb,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [31:0]                     o_rsp_rdata,
    output logic [1:0]                      o_rsp_resp,
    output logic                            o_rsp_timeout
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    // The local command port is fixed at 32 bits and the counter needs at least one bit.
    if (C_M_AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("amba_axi4_lite_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 2");
    end

    master_state_e state_q, state_d;

    logic                          cmd_ready_q, cmd_ready_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          bready_q, bready_d;
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]             wstrb_q, wstrb_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [31:0]                   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                    rsp_resp_q, rsp_resp_d;
    logic                          rsp_timeout_q, rsp_timeout_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic abort;
    logic timeout_hit;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q  & M_AXI_WREADY;
    assign b_hs  = bready_q  & M_AXI_BVALID;
    assign ar_hs = arvalid_q & M_AXI_ARREADY;
    assign r_hs  = rready_q  & M_AXI_RVALID;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             busy;

    assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_RESP);
    assign timeout_hit = busy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: held at zero outside the bus phases so every accepted command starts fresh.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            tmo_cnt_q <= '0;
        end else if (!busy) begin
            tmo_cnt_q <= '0;
        end else if (!timeout_hit) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next value of every registered output; nothing here reaches a port directly.
    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    addr_d    = C_M_AXI_ADDR_WIDTH'(i_cmd_addr);
                    wdata_d   = C_M_AXI_DATA_WIDTH'(i_cmd_wdata);
                    wstrb_d   = STRB_W'(i_cmd_wstrb);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (i_cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d       = RSP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_d       = RSP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'(M_AXI_RDATA);
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                if (rsp_valid_q && i_rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog abandon: release the bus and report a synthetic SLVERR.
        if (abort) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = SLVERR;
            rsp_timeout_d = 1'b1;
        end

        cmd_ready_d = (state_d == IDLE);
    end

    // Output and payload registers.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign o_cmd_ready   = cmd_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_amba_axi4_lite_master.sv
// tb/tb_amba_axi4_lite_master.sv - randomized self-checking bench for amba_axi4_lite_master
module tb_amba_axi4_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [31:0] i_cmd_addr, i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_timeout;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    amba_axi4_lite_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout)
    );

    task automatic slave_idle();
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RDATA   = 32'h0;
    endtask

    // Reference latency: acceptance -> request phase(s) -> response wait -> registered response.
    function automatic int exp_latency(input logic wr, input int dly_a, input int dly_w, input int dly_resp);
        int req;
        req = wr ? ((dly_a > dly_w) ? dly_a : dly_w) : dly_a;
        return 3 + req + dly_resp;
    endfunction

    // Reactive slave plus protocol observer for one command; returns what was seen.
    task automatic do_txn(
        input  logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
        input  int dly_a, input int dly_w, input int dly_resp, input logic [1:0] resp_code,
        input  logic [31:0] rd_word, input int hold,
        output logic [31:0] g_rdata, output logic [1:0] g_resp, output logic g_tmo,
        output int lat, output int nresp, output int na, output int nw,
        output int bad, output int post_bad, output logic expired);
        bit a_done, w_done, r_done, seen, exp_rdy;
        int a_t, w_t, mx, k;
        a_done = 0; w_done = 0; r_done = 0; seen = 0; a_t = 0; w_t = 0;
        lat = -1; nresp = 0; na = 0; nw = 0; bad = 0; post_bad = 0; expired = 1'b0;
        g_rdata = '0; g_resp = '0; g_tmo = 1'b0;
        @(negedge clk);
        slave_idle();
        M_AXI_AWREADY = 1'($urandom_range(0, 1));
        M_AXI_WREADY  = 1'($urandom_range(0, 1));
        M_AXI_ARREADY = 1'($urandom_range(0, 1));
        i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr;
        i_cmd_wdata = wdata; i_cmd_wstrb = strb; i_rsp_ready = 1'b0;
        k = 0;
        while (!o_cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!o_cmd_ready) begin
            expired = 1'b1;
            i_cmd_valid = 1'b0;
            slave_idle();
            return;
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (t == 0) i_cmd_valid = 1'b0;
            if (o_rsp_valid) begin
                seen = 1; lat = t + 1;
                g_rdata = o_rsp_rdata; g_resp = o_rsp_resp; g_tmo = o_rsp_timeout;
                slave_idle();
                break;
            end
            if (o_cmd_ready) bad++;
            if (M_AXI_AWPROT != 3'b000 || M_AXI_ARPROT != 3'b000) bad++;
            if (wr) begin
                if (M_AXI_ARVALID || M_AXI_RREADY) bad++;
                if (M_AXI_AWVALID) begin
                    na++;
                    if (a_done || M_AXI_AWADDR != addr) bad++;
                end
                if (M_AXI_WVALID) begin
                    nw++;
                    if (w_done || M_AXI_WDATA != wdata || M_AXI_WSTRB != strb) bad++;
                end
                mx = (a_t > w_t) ? a_t : w_t;
                exp_rdy = a_done && w_done && !r_done && (t > mx);
                if (M_AXI_BREADY !== exp_rdy) bad++;
                M_AXI_AWREADY = !a_done && (t >= dly_a);
                M_AXI_WREADY  = !w_done && (t >= dly_w);
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin a_done = 1; a_t = t; end
                if (M_AXI_WVALID && M_AXI_WREADY) begin w_done = 1; w_t = t; end
                mx = (a_t > w_t) ? a_t : w_t;
                M_AXI_BVALID = a_done && w_done && !r_done && (t >= mx + 1 + dly_resp);
                M_AXI_BRESP  = M_AXI_BVALID ? resp_code : 2'($urandom);
                if (M_AXI_BVALID && M_AXI_BREADY) begin nresp++; r_done = 1; end
            end else begin
                if (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY) bad++;
                if (M_AXI_ARVALID) begin
                    na++;
                    if (a_done || M_AXI_ARADDR != addr) bad++;
                end
                exp_rdy = a_done && !r_done && (t > a_t);
                if (M_AXI_RREADY !== exp_rdy) bad++;
                M_AXI_ARREADY = !a_done && (t >= dly_a);
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin a_done = 1; a_t = t; end
                M_AXI_RVALID = a_done && !r_done && (t >= a_t + 1 + dly_resp);
                M_AXI_RDATA  = M_AXI_RVALID ? rd_word : $urandom;
                M_AXI_RRESP  = M_AXI_RVALID ? resp_code : 2'($urandom);
                if (M_AXI_RVALID && M_AXI_RREADY) begin nresp++; r_done = 1; end
            end
        end
        if (!seen) begin
            expired = 1'b1;
            slave_idle();
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!o_rsp_valid || o_rsp_rdata != g_rdata || o_rsp_resp != g_resp) bad++;
            if (o_rsp_timeout != g_tmo || o_cmd_ready) bad++;
            if (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID || M_AXI_BREADY || M_AXI_RREADY) bad++;
        end
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
        if (o_rsp_valid || !o_cmd_ready) post_bad++;
    endtask

    logic [31:0] g_rdata;
    logic [1:0]  g_resp;
    logic        g_tmo, expired;
    int          lat, nresp, na, nw, bad, post_bad;

    task automatic test_reset();
        slave_idle();
        i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
        i_cmd_wstrb = '0; i_rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", o_cmd_ready); end
        checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 5'b0) begin
            errors++; $display("FAIL reset_axi_handshakes got %b want 00000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}); end
        checks++; if ({o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_timeout} !== 36'h0) begin
            errors++; $display("FAIL reset_rsp got v=%b d=%h r=%b t=%b want zeros", o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_timeout); end
        checks++; if (M_AXI_AWADDR !== 32'h0 || M_AXI_WDATA !== 32'h0) begin
            errors++; $display("FAIL reset_payload got a=%h d=%h want 0", M_AXI_AWADDR, M_AXI_WDATA); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", o_cmd_ready); end
    endtask

    task automatic test_write_basic();
        do_txn(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0,
               g_rdata, g_resp, g_tmo, lat, nresp, na, nw, bad, post_bad, expired);
        checks++; if (expired) begin errors++; $display("FAIL wr_basic_done got expired want response"); end
        checks++; if (lat != 3) begin errors++; $display("FAIL wr_basic_latency got %0d want 3", lat); end
        checks++; if (g_resp !== 2'b00 || g_rdata !== 32'h0) begin errors++; $display("FAIL wr_basic_rsp got r=%b d=%h want 00/0", g_resp, g_rdata); end
        checks++; if (g_tmo !== 1'b0) begin errors++; $display("FAIL wr_basic_timeout got %b want 0", g_tmo); end
        checks++; if (na != 1 || nw != 1 || nresp != 1) begin errors++; $display("FAIL wr_basic_beats got aw=%0d w=%0d b=%0d want 1/1/1", na, nw, nresp); end
        checks++; if (bad != 0 || post_bad != 0) begin errors++; $display("FAIL wr_basic_protocol got %0d/%0d violations want 0", bad, post_bad); end
    endtask

    task automatic test_skewed_write();
        do_txn(1'b1, 32'h8, 32'h12345678, 4'h5, 0, 4, 0, 2'b00, 32'h0, 0,
               g_rdata, g_resp, g_tmo, lat, nresp, na, nw, bad, post_bad, expired);
        checks++; if (na != 1 || nw != 5) begin errors++; $display("FAIL skew_valid_cycles got aw=%0d w=%0d want 1/5", na, nw); end
        checks++; if (nresp != 1) begin errors++; $display("FAIL skew_b_count got %0d want 1", nresp); end
        checks++; if (lat != exp_latency(1'b1, 0, 4, 0)) begin errors++; $display("FAIL skew_latency got %0d want %0d", lat, exp_latency(1'b1, 0, 4, 0)); end
        checks++; if (bad != 0 || expired) begin errors++; $display("FAIL skew_protocol got %0d violations exp=%b want 0", bad, expired); end
    endtask

    task automatic test_read();
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 2, 2'b00, 32'h00000007, 0,
               g_rdata, g_resp, g_tmo, lat, nresp, na, nw, bad, post_bad, expired);
        checks++; if (g_rdata !== 32'h7 || g_resp !== 2'b00) begin errors++; $display("FAIL rd_rsp got d=%h r=%b want 00000007/00", g_rdata, g_resp); end
        checks++; if (lat != 5) begin errors++; $display("FAIL rd_latency got %0d want 5", lat); end
        checks++; if (bad != 0 || post_bad != 0 || expired) begin errors++; $display("FAIL rd_rready_window got %0d violations want 0", bad); end
    endtask

    task automatic test_error();
        do_txn(1'b1, 32'h100, 32'hCAFEF00D, 4'h3, 0, 0, 0, 2'b10, 32'h0, 5,
               g_rdata, g_resp, g_tmo, lat, nresp, na, nw, bad, post_bad, expired);
        checks++; if (g_resp !== 2'b10 || g_rdata !== 32'h0) begin errors++; $display("FAIL err_passthrough got r=%b d=%h want 10/0", g_resp, g_rdata); end
        checks++; if (na != 1 || nresp != 1) begin errors++; $display("FAIL err_no_retry got aw=%0d b=%0d want 1/1", na, nresp); end
        checks++; if (bad != 0 || post_bad != 0 || expired) begin errors++; $display("FAIL err_hold_stable got %0d/%0d violations want 0", bad, post_bad); end
    endtask

    task automatic test_random();
        logic        wr;
        logic [31:0] addr, wdata, rd_word, exp_rdata;
        logic [3:0]  strb;
        logic [1:0]  resp_code;
        int          da, dw, dr, hold;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            addr = {$urandom_range(0, 255), 2'b00}[31:0];
            wdata = $urandom; rd_word = $urandom; strb = 4'($urandom);
            resp_code = 2'($urandom);
            da = $urandom_range(0, 3); dw = $urandom_range(0, 3); dr = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            exp_rdata = wr ? 32'h0 : rd_word;
            do_txn(wr, addr, wdata, strb, da, dw, dr, resp_code, rd_word, hold,
                   g_rdata, g_resp, g_tmo, lat, nresp, na, nw, bad, post_bad, expired);
            checks++; if (expired) begin errors++; $display("FAIL rand%0d_done got expired want response", i); end
            checks++; if (g_rdata !== exp_rdata) begin errors++; $display("FAIL rand%0d_rdata got %h want %h", i, g_rdata, exp_rdata); end
            checks++; if (g_resp !== resp_code) begin errors++; $display("FAIL rand%0d_resp got %b want %b", i, g_resp, resp_code); end
            checks++; if (g_tmo !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got %b want 0", i, g_tmo); end
            checks++; if (lat != exp_latency(wr, da, dw, dr)) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, exp_latency(wr, da, dw, dr)); end
            checks++; if (na != da + 1 || nw != (wr ? dw + 1 : 0)) begin errors++; $display("FAIL rand%0d_valid_cycles got a=%0d w=%0d want %0d/%0d", i, na, nw, da + 1, wr ? dw + 1 : 0); end
            checks++; if (nresp != 1) begin errors++; $display("FAIL rand%0d_resp_beats got %0d want 1", i, nresp); end
            checks++; if (bad != 0 || post_bad != 0) begin errors++; $display("FAIL rand%0d_protocol got %0d/%0d violations want 0", i, bad, post_bad); end
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        bit quiet;
        @(negedge clk);
        slave_idle();
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 32'h40;
        i_cmd_wdata = 32'hA5A5A5A5; i_cmd_wstrb = 4'hF;
        k = 0;
        while (!o_cmd_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        i_cmd_valid = 1'b0;
        checks++; if (M_AXI_AWVALID !== 1'b1 || M_AXI_WVALID !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_flight got aw=%b w=%b want 1/1", M_AXI_AWVALID, M_AXI_WVALID); end
        #2 rst = 1'b1;
        #1;
        checks++; if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0 || o_cmd_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got aw=%b w=%b rdy=%b want 0/0/0", M_AXI_AWVALID, M_AXI_WVALID, o_cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle got cmd_ready=%b want 1", o_cmd_ready); end
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (o_rsp_valid || M_AXI_AWVALID || M_AXI_WVALID) quiet = 0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rstmid_no_rsp got activity after reset want none"); end
    endtask

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit quiet;
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1000, 0, 0, 2'b00, 32'h0, 0,
               g_rdata, g_resp, g_tmo, lat, nresp, na, nw, bad, post_bad, expired);
        checks++; if (expired || g_tmo !== 1'b1 || g_resp !== 2'b10 || g_rdata !== 32'h0) begin
            errors++; $display("FAIL tmo_rsp got exp=%b t=%b r=%b d=%h want 0/1/10/0", expired, g_tmo, g_resp, g_rdata); end
        checks++; if (na != 16 || lat != 17) begin errors++; $display("FAIL tmo_timing got arvalid=%0d lat=%0d want 16/17", na, lat); end
        @(negedge clk);
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h55; M_AXI_BVALID = 1'b1;
        quiet = 1;
        repeat (3) begin
            @(negedge clk);
            if (M_AXI_RREADY || M_AXI_BREADY || o_rsp_valid) quiet = 0;
        end
        slave_idle();
        checks++; if (!quiet) begin errors++; $display("FAIL tmo_late_rsp got ready/rsp activity want none"); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_skewed_write();
        test_read();
        test_error();
        test_random();
        test_reset_mid_write();
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/amba_axi4_lite_master.md
Name: amba_axi4_lite_master

Overview:
- AXI4-Lite initiator (master) that turns single-beat local read/write commands into AXI4-Lite transactions.
- Drives the adder register-bank slave from an on-chip controller or bring-up sequencer, replacing the PS-side master in standalone FPGA builds.
- One outstanding transaction at a time. Result (read data plus response code) is returned over a valid/ready response port.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  reset, asynchronous, active-high.
- M_AXI_AWADDR  out  ADDR_W  write address.
- M_AXI_AWPROT  out  3  tied 3'b000.
- M_AXI_AWVALID/M_AXI_AWREADY  out/in  1  write-address handshake.
- M_AXI_WDATA  out  DATA_W  write data.
- M_AXI_WSTRB  out  DATA_W/8  write strobes.
- M_AXI_WVALID/M_AXI_WREADY  out/in  1  write-data handshake.
- M_AXI_BRESP  in  2  write response code.
- M_AXI_BVALID/M_AXI_BREADY  in/out  1  write-response handshake.
- M_AXI_ARADDR  out  ADDR_W  read address.
- M_AXI_ARPROT  out  3  tied 3'b000.
- M_AXI_ARVALID/M_AXI_ARREADY  out/in  1  read-address handshake.
- M_AXI_RDATA  in  DATA_W  read data.
- M_AXI_RRESP  in  2  read response code.
- M_AXI_RVALID/M_AXI_RREADY  in/out  1  read-data handshake.
- i_cmd_valid/o_cmd_ready  in/out  1  command handshake.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  32  target address.
- i_cmd_wdata  in  32  write data.
- i_cmd_wstrb  in  4  write strobes.
- o_rsp_valid/i_rsp_ready  out/in  1  response handshake.
- o_rsp_rdata  out  32  read data; 0 for writes.
- o_rsp_resp  out  2  AXI response code (OKAY/EXOKAY/SLVERR/DECERR).
- o_rsp_timeout  out  1  transaction abandoned by the watchdog.

Behaviour:
- Reset: all VALID/READY outputs 0, o_cmd_ready 0, o_rsp_* 0, address/data registers 0, state IDLE. Takes effect immediately on assertion, mid-transaction included; the in-flight transaction is lost and no response is produced.
- All AXI outputs and o_rsp_* are registered (no combinational path from AXI inputs).
- IDLE: o_cmd_ready=1. On i_cmd_valid the command is latched.
  - Write command → WR_REQ, with AWVALID=WVALID=1 in the next cycle.
  - Read command → RD_REQ, with ARVALID=1 in the next cycle.
- WR_REQ:
  - AW and W channels complete independently. Each VALID stays high, with stable payload, until its own READY is sampled high, then drops. Per-channel done flags are kept.
  - Same-cycle AWREADY and WREADY completes both.
  - When both are done → WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP, set o_rsp_rdata=0, BREADY drops the next cycle → RSP.
- RD_REQ: ARVALID held until ARREADY → RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA and RRESP → RSP.
- RSP: o_rsp_valid=1, payload stable until i_rsp_ready, then → IDLE. o_cmd_ready stays 0 in every state except IDLE.
- Minimum latency: against a slave with AWREADY/WREADY/ARREADY held high and a one-cycle response, o_rsp_valid rises 3 cycles after command acceptance.
- VALID never depends on READY (AXI rule). A slave READY arriving before VALID is ignored.
- SLVERR and DECERR are passed through unchanged; the block does not retry.

Optional Feature:
- Macro: AXI4_LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on command acceptance and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - On reaching TIMEOUT_CYCLES-1: all VALID/READY outputs drop, o_rsp_resp=SLVERR, o_rsp_timeout=1, o_rsp_rdata=0 → RSP.
  - A late B or R response arriving afterwards is ignored; BREADY/RREADY stay 0 in IDLE.
- Undefined: no counter; the block waits indefinitely and o_rsp_timeout is tied to 0.

Decomposition:
- Package amba_axi4_lite_pkg holds:
  - the AXI4-Lite response enum (OKAY, EXOKAY, SLVERR, DECERR);
  - the master state enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP);
  - width constants (SIZE_ADDR=32, SIZE_STRB=4).
- The slave is refactored to use the same package.
- Sub-module: none. The watchdog is a single counter inside the ifdef.

Test Plan:
- Write with an always-ready slave: cmd write addr 0x04, data 0xDEADBEEF, strb 0xF → AW/W valid 1 cycle later; BRESP OKAY; o_rsp_valid 3 cycles after acceptance with resp=00, rdata=0.
- Skewed write: WREADY 4 cycles after AWREADY → AWVALID drops after its handshake, WVALID held with stable data until WREADY; exactly one B accepted.
- Read: addr 0x10, slave returns 0x00000007 OKAY after 2 wait cycles → o_rsp_rdata=0x00000007, resp=00; RREADY high exactly until the RVALID handshake.
- Error passthrough: write to 0x100, slave BRESP=SLVERR → o_rsp_resp=10, no retry. Hold i_rsp_ready=0 for 5 cycles → response stable and o_cmd_ready=0 throughout.
- Reset mid-write: assert M_AXI_ARESET while AWVALID=1 → AWVALID/WVALID 0 asynchronously; after release state is IDLE, o_cmd_ready=1 and no o_rsp_valid.
- With AXI4_LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16: slave never asserts ARREADY → ARVALID drops at cycle 16; o_rsp_timeout=1, resp=10.
